averager_simple: RTL and testbench
==================================

// Module: averager_simple
// PURPOSE
//  Block averager for the discrete-ADC front end. Sums 2**power consecutive 8-bit ADC
//  samples, then publishes a 16-bit result that trades sample rate for resolution.
//  Q[15:8] is the integer mean in ADC codes; Q[7:0] carries the extra fractional bits.
// PARAMETERS
//  power  8  log2 of samples per block; legal range 1..12
// PORTS
//  clk    in   1   system clock; all state updates on the rising edge
//  reset  in   1   reset, synchronous, active-low (0 = reset)
//  EN     in   1   sample enable; Din is taken on each rising edge where EN=1
//  Din    in   8   unsigned ADC sample
//  Q      out  16  registered, scaled block average
// BEHAVIOUR
//  - Reset (reset=0 at a rising edge): Q, accumulator and sample counter all go to 0.
//    Reset overrides EN and discards any partial block.
//  - Accumulator is unsigned, 8+power bits wide; it cannot overflow.
//  - Sample counter is power bits wide, counts 0..2**power-1, then wraps.
//  - Edge with EN=1 and counter < 2**power-1: acc <= acc+Din, counter increments, Q holds.
//  - Edge with EN=1 and counter == 2**power-1 (last sample of the block):
//    - Q <= scale(acc+Din); acc <= 0; counter <= 0.
//    - Q is valid one cycle after the edge that takes the last sample.
//  - Edge with EN=0: Q holds; acc/counter follow CONFIGURATION.
//  - Q changes only on a block boundary or reset. First valid Q arrives 2**power
//    enabled samples after reset is released.
//  - scale(S), where S is 8+power bits:
//    - power<8: S << (8-power)
//    - power=8: S
//    - power>8: S >> (power-8), truncating
//    - Every case gives scale(2**power * D) == {D,8'h00} for any constant D.
//  - Q never saturates or wraps; max is 0xFF00 for constant Din = 0xFF.
//  - Back-to-back blocks: the edge after a dump is sample 0 of the next block;
//    no samples are lost.
// CONFIGURATION
//  - AVERAGER_CLEAR_ON_DISABLE_EN defined: an edge with EN=0 clears acc and counter
//    to 0 and discards the partial block. The next enabled sample starts a fresh block.
//  - Not defined (default): an edge with EN=0 freezes acc and counter. The block
//    resumes when EN returns, so disabled cycles are skipped, not counted.
//  - Q holds in both modes.
// STRUCTURE
//  - Package averager_pkg:
//    - DIN_W=8, Q_W=16
//    - function acc_w(power) = DIN_W+power
//    - function scale_to_q(sum, power) implementing scale()
//  - Sub-module averager_sample_counter, param power:
//    - counter with EN/clear inputs and a last_sample output (EN && count==2**power-1)
//  - Top level: accumulator, Q register, counter instance.
// TESTING
//  1. Hold reset=0 for 10 cycles with EN=1, Din=0xAA
//     -> Q=0x0000 throughout and for 256 cycles after release.
//  2. power=8, EN=1, Din=0x10 for 512 cycles
//     -> Q=0x1000 one cycle after the 256th sample and stays 0x1000.
//  3. power=8, Din=0x55 plus uniform noise in -4..+4
//     -> every dumped Q lies in 0x5100..0x5900; Q[15:8] within +-1 of 0x55.
//  4. Sequence 0x10 -> 0x05 -> 0xB7, 512 cycles each
//     -> Q steps to 0x1000, then 0x0500, then 0xB700, each exactly at a block boundary.
//  5. power=4, constant 0xB7 -> Q=0xB700.
//     power=10, constant 0xB7 -> Q=0xB700.
//     power=10, alternating 0x00/0x01 -> Q=0x0080.
//  6. EN=0 for 50 cycles mid-block, then resume, constant 0x20:
//     - default -> dump after 256 enabled samples, Q=0x2000.
//     - with macro -> dump 256 samples after resume.
//     Reset mid-block -> Q=0 and a full new block is required.

Source files
------------

// File: rtl/averager_pkg.sv
// -----------------------------------------------------------------------------
// averager_pkg
// Shared widths, the disabled-cycle policy type and the helper functions used
// by the block averager.
//   DIN_W / Q_W   : ADC sample width and published result width
//   acc_w()       : accumulator width for a given block size exponent
//   scale_to_q()  : maps a full block sum onto the 16-bit result, so that a
//                   block of constant samples D yields {D, 8'h00}
// Configuration macro: AVERAGER_CLEAR_ON_DISABLE_EN (selected in averager_simple)
// -----------------------------------------------------------------------------
package averager_pkg;

    localparam int DIN_W     = 8;
    localparam int Q_W       = 16;
    localparam int POWER_MAX = 12;
    // Widest block sum any legal configuration can produce.
    localparam int SUM_MAX_W = DIN_W + POWER_MAX;

    // What an edge with EN=0 does to a partially accumulated block.
    typedef enum logic {
        DIS_FREEZE = 1'b0,  // hold acc/counter, resume the block later
        DIS_CLEAR  = 1'b1   // drop the partial block
    } dis_mode_e;

    function automatic int acc_w(input int power);
        return DIN_W + power;
    endfunction

    // The sum of 2**power samples carries power extra bits of resolution;
    // align it so the integer mean lands in Q[15:8].
    function automatic logic [Q_W-1:0] scale_to_q(input logic [SUM_MAX_W-1:0] sum,
                                                 input int unsigned power);
        logic [SUM_MAX_W+7:0] wide;
        wide = {8'h00, sum};
        if (power < 8)
            wide = wide << (8 - power);
        else if (power > 8)
            wide = wide >> (power - 8);
        return wide[Q_W-1:0];
    endfunction

endpackage

// File: rtl/averager_sample_counter.sv
// -----------------------------------------------------------------------------
// averager_sample_counter
// Counts enabled samples within one block (0 .. 2**power-1, then wraps) and
// flags the edge that takes the last sample of the block.
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-low
//   en_i           sample enable; advances the count
//   clear_i        returns the count to 0 on a non-enabled edge
//   last_sample_o  en_i && count == 2**power-1 (combinational)
// -----------------------------------------------------------------------------
module averager_sample_counter #(
    parameter int power = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic clear_i,
    output logic last_sample_o
);

    logic [power-1:0] count_q;
    logic [power-1:0] count_d;

    // The natural power-bit wrap returns the count to 0 after the last sample.
    always_comb begin
        count_d = count_q;
        if (en_i)
            count_d = count_q + power'(1);
        else if (clear_i)
            count_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign last_sample_o = en_i && (count_q == '1);

endmodule

// File: rtl/averager_simple.sv
// -----------------------------------------------------------------------------
// averager_simple
// Block averager for the discrete-ADC front end. Sums 2**power enabled 8-bit
// samples and publishes a registered 16-bit scaled average at each block
// boundary: Q[15:8] is the integer mean, Q[7:0] the extra fractional bits.
// Parameter:
//   power  log2 of samples per block, 1..12
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low; clears Q, accumulator and counter
//   EN     sample enable; Din is taken on each rising edge with EN=1
//   Din    unsigned ADC sample
//   Q      registered block average, changes only at block end or reset
// Configuration macro:
//   AVERAGER_CLEAR_ON_DISABLE_EN  defined: EN=0 discards the partial block
//                                 undefined: EN=0 freezes the partial block
// -----------------------------------------------------------------------------
module averager_simple
    import averager_pkg::*;
#(
    parameter int power = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             EN,
    input  logic [DIN_W-1:0] Din,
    output logic [Q_W-1:0]   Q
);

    localparam int ACC_W = acc_w(power);

`ifdef AVERAGER_CLEAR_ON_DISABLE_EN
    localparam dis_mode_e DIS_MODE = DIS_CLEAR;
`else
    localparam dis_mode_e DIS_MODE = DIS_FREEZE;
`endif

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] acc_sum;
    logic [Q_W-1:0]   q_q;
    logic [Q_W-1:0]   q_d;
    logic             last_sample;
    logic             clear_idle;

    // 2**power samples of at most 8'hFF fit in DIN_W+power bits, so no carry out.
    assign acc_sum    = acc_q + ACC_W'(Din);
    assign clear_idle = (DIS_MODE == DIS_CLEAR) && !EN;

    averager_sample_counter #(
        .power (power)
    ) u_counter (
        .clk           (clk),
        .reset         (reset),
        .en_i          (EN),
        .clear_i       (clear_idle),
        .last_sample_o (last_sample)
    );

    always_comb begin
        acc_d = acc_q;
        q_d   = q_q;
        if (last_sample) begin
            // The last sample is folded in here so the dump edge also
            // starts the next block from an empty accumulator.
            q_d   = scale_to_q(SUM_MAX_W'(acc_sum), int'(power));
            acc_d = '0;
        end else if (EN) begin
            acc_d = acc_sum;
        end else if (clear_idle) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q <= '0;
            q_q   <= '0;
        end else begin
            acc_q <= acc_d;
            q_q   <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: tb/tb_averager_simple.sv
// -----------------------------------------------------------------------------
// tb_averager_simple
// Drives three averager instances (power = 8, 4, 10) from one shared stimulus
// stream and compares their Q outputs with hand-computed values.
// -----------------------------------------------------------------------------
module tb_averager_simple;

    logic        clk;
    logic        reset;
    logic        EN;
    logic [7:0]  Din;
    logic [15:0] q8;
    logic [15:0] q4;
    logic [15:0] q10;

    int unsigned errors;
    int unsigned checks;

    averager_simple #(.power(8)) dut8 (
        .clk(clk), .reset(reset), .EN(EN), .Din(Din), .Q(q8)
    );
    averager_simple #(.power(4)) dut4 (
        .clk(clk), .reset(reset), .EN(EN), .Din(Din), .Q(q4)
    );
    averager_simple #(.power(10)) dut10 (
        .clk(clk), .reset(reset), .EN(EN), .Din(Din), .Q(q10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [7:0]  din;
        int unsigned cycles;
        logic [15:0] exp8;
        logic [15:0] exp4;
        logic [15:0] exp10;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Apply one set of inputs for one rising edge; return 1 ns after the edge.
    task automatic step(input logic en, input logic [7:0] din);
        EN  = en;
        Din = din;
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input logic en, input logic [7:0] din, input int unsigned n);
        for (int unsigned k = 0; k < n; k++) step(en, din);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(1'b1, 8'hAA);
        reset = 1'b1;
    endtask

    int unsigned bad;
    logic [7:0]  nd;
    int          noise;

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        EN     = 1'b1;
        Din    = 8'hAA;

        // Reset held with EN=1 must keep everything at zero.
        bad = 0;
        for (int unsigned k = 0; k < 10; k++) begin
            step(1'b1, 8'hAA);
            if (q8 !== 16'h0 || q4 !== 16'h0 || q10 !== 16'h0) bad++;
        end
        chk("reset_hold_zero_cycles", 16'(bad), 16'h0);
        chk("reset_q8", q8, 16'h0000);
        chk("reset_q10", q10, 16'h0000);
        reset = 1'b1;

        // 255 enabled samples after release: no dump yet on power=8.
        bad = 0;
        for (int unsigned k = 0; k < 255; k++) begin
            step(1'b1, 8'hAA);
            if (q8 !== 16'h0) bad++;
        end
        chk("post_release_q8_zero_cycles", 16'(bad), 16'h0);
        step(1'b1, 8'hAA);
        chk("first_dump_q8", q8, 16'hAA00);
        chk("first_dump_q10_none", q10, 16'h0000);

        // Table of phases, applied back to back from a fresh reset.
        vecs[0] = '{1'b1, 8'h10,  255, 16'h0000, 16'h1000, 16'h0000};
        vecs[1] = '{1'b1, 8'h10,    1, 16'h1000, 16'h1000, 16'h0000};
        vecs[2] = '{1'b1, 8'h10,  256, 16'h1000, 16'h1000, 16'h0000};
        vecs[3] = '{1'b1, 8'h05,  255, 16'h1000, 16'h0500, 16'h0000};
        vecs[4] = '{1'b1, 8'h05,    1, 16'h0500, 16'h0500, 16'h0000};
        // 1024-sample block on power=10: (512*0x10+256*0x05+256*0xB7)>>2 = 0x3700
        vecs[5] = '{1'b1, 8'hB7,  256, 16'hB700, 16'hB700, 16'h3700};
        vecs[6] = '{1'b1, 8'hB7, 1024, 16'hB700, 16'hB700, 16'hB700};
        vecs[7] = '{1'b0, 8'h33,   50, 16'hB700, 16'hB700, 16'hB700};
        vecs[8] = '{1'b1, 8'hFF, 1024, 16'hFF00, 16'hFF00, 16'hFF00};

        do_reset();
        for (int unsigned v = 0; v < 9; v++) begin
            steps(vecs[v].en, vecs[v].din, vecs[v].cycles);
            chk($sformatf("vec%0d_q8", v),  q8,  vecs[v].exp8);
            chk($sformatf("vec%0d_q4", v),  q4,  vecs[v].exp4);
            chk($sformatf("vec%0d_q10", v), q10, vecs[v].exp10);
        end

        // Alternating 0x00/0x01: every block size averages to 0.5 code.
        do_reset();
        for (int unsigned k = 0; k < 1024; k++) step(1'b1, 8'(k & 1));
        chk("alt_q10", q10, 16'h0080);
        chk("alt_q8",  q8,  16'h0080);
        chk("alt_q4",  q4,  16'h0080);

        // 0x55 with uniform noise in -4..+4, checked at each power=8 dump.
        do_reset();
        for (int unsigned b = 0; b < 4; b++) begin
            for (int unsigned k = 0; k < 256; k++) begin
                noise = int'($urandom_range(8)) - 4;
                nd    = 8'(32'sh55 + noise);
                step(1'b1, nd);
            end
            chk($sformatf("noise_blk%0d_range", b), 16'((q8 >= 16'h5100) && (q8 <= 16'h5900)), 16'h1);
            chk($sformatf("noise_blk%0d_mean", b),
                16'((q8[15:8] >= 8'h54) && (q8[15:8] <= 8'h56)), 16'h1);
        end

        // 50 disabled cycles in the middle of a 0x20 block (Din=0xFF while idle).
        do_reset();
        steps(1'b1, 8'h20, 100);
        steps(1'b0, 8'hFF, 50);
        chk("gap_q8_hold", q8, 16'h0000);
        chk("gap_q4", q4, 16'h2000);
        steps(1'b1, 8'h20, 155);
        chk("gap_q8_before", q8, 16'h0000);
        step(1'b1, 8'h20);
`ifdef AVERAGER_CLEAR_ON_DISABLE_EN
        chk("gap_q8_partial_dropped", q8, 16'h0000);
        steps(1'b1, 8'h20, 99);
        chk("gap_q8_before_fresh", q8, 16'h0000);
        step(1'b1, 8'h20);
        chk("gap_q8_fresh_block", q8, 16'h2000);
`else
        chk("gap_q8_resumed_block", q8, 16'h2000);
`endif

        // Reset mid-block discards the partial sum and clears Q.
        steps(1'b1, 8'h40, 100);
        reset = 1'b0;
        step(1'b1, 8'h40);
        reset = 1'b1;
        chk("midreset_q8", q8, 16'h0000);
        chk("midreset_q4", q4, 16'h0000);
        steps(1'b1, 8'h40, 255);
        chk("midreset_q8_before", q8, 16'h0000);
        step(1'b1, 8'h40);
        chk("midreset_q8_full_block", q8, 16'h4000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
